// File: rtl/cpu_wb_pkg.sv
// Shared types and constants for the CPU-to-Wishbone bridge and its peripherals.
package cpu_wb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDone
  } state_e;

  localparam int unsigned DefAw      = 8;
  localparam logic [15:0] DefBase    = 16'h0000;
  localparam int unsigned DefTimeout = 15;

  // ALU peripheral register map (byte offsets inside the window)
  localparam logic [7:0] RegA     = 8'h80;
  localparam logic [7:0] RegB     = 8'h81;
  localparam logic [7:0] RegOp    = 8'h82;
  localparam logic [7:0] RegOut   = 8'h83;
  localparam logic [7:0] RegFlags = 8'h84;

  function automatic logic in_window(input logic [15:0] addr, input logic [15:0] base,
                                     input int unsigned aw);
    return (addr >> aw) == (base >> aw);
  endfunction

endpackage

// File: rtl/wb_timeout_ctr.sv
// Saturating cycle counter; tc_o marks the last cycle of the allowed bus window.
module wb_timeout_ctr #(
  parameter int unsigned Limit = 15
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CntW = $clog2(Limit + 1);

  logic [CntW-1:0] cnt_q;

  // tc fires while the Limit-th cycle is in progress so the abort lands after it
  assign tc_o = (cnt_q == CntW'(Limit - 1));

  always_ff @(posedge clk_i) begin
    if (reset_i || clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !tc_o) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/cpu_wb_bridge.sv
// Single-transfer CPU load/store to pipelined Wishbone master with window decode and timeout.
module cpu_wb_bridge
  import cpu_wb_pkg::*;
#(
  parameter int unsigned AW      = DefAw,
  parameter logic [15:0] BASE    = DefBase,
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input  logic          i_clk,
  input  logic          reset,
  input  logic          i_cpu_req,
  input  logic          i_cpu_we,
  input  logic [15:0]   i_cpu_addr,
  input  logic [7:0]    i_cpu_data,
  output logic          o_cpu_rdy,
  output logic          o_cpu_err,
  output logic [7:0]    o_cpu_data,
  output logic          o_busy,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic          o_wb_we,
  output logic [AW-1:0] o_wb_addr,
  output logic [7:0]    o_wb_data,
  input  logic          i_wb_stall,
  input  logic          i_wb_ack,
  input  logic [7:0]    i_wb_data
);

  state_e          state_q;
  logic            cyc_q, stb_q, we_q, rdy_q, err_q;
  logic [AW-1:0]   addr_q;
  logic [7:0]      wdata_q, rdata_q;
  logic            in_win, tmo_tc, tmo_clr, tmo_en;

  assign in_win  = in_window(i_cpu_addr, BASE, AW);
  assign tmo_clr = (state_q == StIdle) && i_cpu_req && in_win;
  assign tmo_en  = (state_q == StReq) || (state_q == StWait);

  wb_timeout_ctr #(
    .Limit (TIMEOUT)
  ) u_timeout (
    .clk_i   (i_clk),
    .reset_i (reset),
    .clr_i   (tmo_clr),
    .en_i    (tmo_en),
    .tc_o    (tmo_tc)
  );

  always_ff @(posedge i_clk) begin
    if (reset) begin
      state_q <= StIdle;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      rdy_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_cpu_req) begin
            we_q    <= i_cpu_we;
            addr_q  <= i_cpu_addr[AW-1:0];
            wdata_q <= i_cpu_data;
            if (in_win) begin
              state_q <= StReq;
              cyc_q   <= 1'b1;
              stb_q   <= 1'b1;
            end else begin
              state_q <= StDone;
            end
          end
        end
        StReq, StWait: begin
          // Ack counts in REQ only together with acceptance; ack beats timeout
          if (i_wb_ack && (state_q == StWait || !i_wb_stall)) begin
            state_q <= StDone;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            rdy_q   <= 1'b1;
            err_q   <= 1'b0;
            if (!we_q) rdata_q <= i_wb_data;
          end else if (tmo_tc) begin
            state_q <= StDone;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            rdy_q   <= 1'b1;
            err_q   <= 1'b1;
          end else if (state_q == StReq && !i_wb_stall) begin
            state_q <= StWait;
            stb_q   <= 1'b0;
          end
        end
        StDone: begin
          // Bus completions arrive with rdy already set; decode errors pulse it here
          if (rdy_q) begin
            state_q <= StIdle;
            err_q   <= 1'b0;
          end else begin
            rdy_q <= 1'b1;
            err_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_cpu_rdy  = rdy_q;
  assign o_cpu_err  = err_q;
  assign o_cpu_data = rdata_q;
  assign o_busy     = (state_q != StIdle);
  assign o_wb_cyc   = cyc_q;
  assign o_wb_stb   = stb_q;
  assign o_wb_we    = we_q;
  assign o_wb_addr  = addr_q;
  assign o_wb_data  = wdata_q;

endmodule
